// File: rtl/dynamic_deobfuscation_rx_if.sv
// rtl/dynamic_deobfuscation_rx_if.sv - link, key and status bundle for the deobfuscation receiver
interface dynamic_deobfuscation_rx_if #(
  parameter int BitNo = 64
);
  logic [BitNo-1:0] DataIn;
  logic             DataInValid;
  logic [BitNo-1:0] InputKey;
  logic             KeyLoad;
  logic [BitNo-1:0] GKey;
  logic [BitNo-1:0] DataOut;
  logic             Data_valid;
  logic             Unlocked;
  logic             LockedOut;
  logic [3:0]       FailCount;
  logic [15:0]      WordCount;
  logic [BitNo-1:0] Checksum;
  logic [15:0]      DropCount;

  modport master (
    output DataIn, DataInValid, InputKey, KeyLoad, GKey,
    input  DataOut, Data_valid, Unlocked, LockedOut, FailCount, WordCount, Checksum, DropCount
  );

  modport slave (
    input  DataIn, DataInValid, InputKey, KeyLoad, GKey,
    output DataOut, Data_valid, Unlocked, LockedOut, FailCount, WordCount, Checksum, DropCount
  );
endinterface

// File: rtl/dynamic_deobfuscation_rx.sv
// rtl/dynamic_deobfuscation_rx.sv - key-authenticated receiver gating an obfuscated word stream
module dynamic_deobfuscation_rx #(
  parameter int BitNo         = 64,
  parameter int MaxFail       = 3,
  parameter int LockoutCycles = 16,
  parameter int SessionWords  = 256
) (
  input logic                   Clk,
  input logic                   Rst_n,
  dynamic_deobfuscation_rx_if.slave bus
);

  localparam int              TW          = (LockoutCycles > 1) ? $clog2(LockoutCycles) : 1;
  localparam logic [TW-1:0]   TIMER_LOAD  = TW'(LockoutCycles - 1);
  localparam logic [3:0]      MAX_FAIL    = 4'(MaxFail);
  localparam logic [15:0]     SESSION_MAX = 16'(SessionWords);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_CHECK    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  state_t           state;
  logic [BitNo-1:0] key_reg;
  logic [TW-1:0]    timer;
  logic [3:0]       fail_count;
  logic [15:0]      word_count;
  logic [BitNo-1:0] checksum;
  logic [15:0]      drop_count;
  logic [BitNo-1:0] data_out;
  logic             data_valid;
  logic             unlocked;
  logic             locked_out;

  logic [15:0]      drop_next;
  logic             key_ok;
  logic             session_end;

  assign drop_next   = (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;
  assign key_ok      = (key_reg == bus.GKey);
  // The word being accepted now is the last one this session may carry.
  assign session_end = bus.DataInValid && (word_count + 16'd1 == SESSION_MAX);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state      <= ST_LOCKED;
      key_reg    <= '0;
      timer      <= '0;
      fail_count <= '0;
      word_count <= '0;
      checksum   <= '0;
      drop_count <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        ST_LOCKED: begin
          if (bus.DataInValid) drop_count <= drop_next;
          if (bus.KeyLoad) begin
            key_reg <= bus.InputKey;
            state   <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (bus.DataInValid) drop_count <= drop_next;
          if (key_ok) begin
            state      <= ST_UNLOCKED;
            unlocked   <= 1'b1;
            fail_count <= '0;
            word_count <= '0;
            checksum   <= '0;
          end else if (fail_count + 4'd1 == MAX_FAIL) begin
            fail_count <= MAX_FAIL;
            timer      <= TIMER_LOAD;
            state      <= ST_LOCKOUT;
            locked_out <= 1'b1;
          end else begin
            fail_count <= fail_count + 4'd1;
            state      <= ST_LOCKED;
          end
        end

        ST_UNLOCKED: begin
          // A golden key change revokes the session before the word is released.
          if (!key_ok) begin
            if (bus.DataInValid) drop_count <= drop_next;
            state    <= ST_LOCKED;
            unlocked <= 1'b0;
          end else begin
            if (bus.DataInValid) begin
              data_out   <= bus.DataIn;
              data_valid <= 1'b1;
              checksum   <= checksum ^ bus.DataIn;
              word_count <= word_count + 16'd1;
            end
            if (session_end) begin
              state    <= ST_LOCKED;
              unlocked <= 1'b0;
            end else if (bus.KeyLoad) begin
              key_reg  <= bus.InputKey;
              state    <= ST_CHECK;
              unlocked <= 1'b0;
            end
          end
        end

        ST_LOCKOUT: begin
          if (bus.DataInValid) drop_count <= drop_next;
          if (timer == '0) begin
            fail_count <= '0;
            state      <= ST_LOCKED;
            locked_out <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        default: state <= ST_LOCKED;
      endcase
    end
  end

  assign bus.DataOut    = data_out;
  assign bus.Data_valid = data_valid;
  assign bus.Unlocked   = unlocked;
  assign bus.LockedOut  = locked_out;
  assign bus.FailCount  = fail_count;
  assign bus.WordCount  = word_count;
  assign bus.Checksum   = checksum;
  assign bus.DropCount  = drop_count;

endmodule

// File: doc/dynamic_deobfuscation_rx.md
Name: dynamic_deobfuscation_rx

Overview:
Receive-side counterpart of the dynamic obfuscation block. It consumes the 64-bit obfuscated word stream and authenticates a loaded key against GKey. Only while a session is authenticated does it forward words as valid data. It also enforces failed-attempt lockout, session expiry and a running XOR checksum, and sits between the obfuscated link and the protected consumer logic.

Parameters:
BitNo, 64, data/key width
MaxFail, 3, consecutive failed key checks that trigger lockout (1..15)
LockoutCycles, 16, cycles spent in LOCKOUT (>=1)
SessionWords, 256, words accepted per authenticated session before forced re-key (1..65535)

Ports:
Clk  input  1  clock, all logic on rising edge
Rst_n  input  1  synchronous active-low reset
DataIn  input  BitNo  obfuscated word from link
DataInValid  input  1  DataIn qualifier, one word per cycle
InputKey  input  BitNo  candidate key
KeyLoad  input  1  capture InputKey and start a check
GKey  input  BitNo  golden key, may change at any cycle
DataOut  output  BitNo  registered recovered word
Data_valid  output  1  one-cycle pulse, DataOut is new
Unlocked  output  1  high in UNLOCKED
LockedOut  output  1  high in LOCKOUT
FailCount  output  4  consecutive failed checks
WordCount  output  16  words accepted this session
Checksum  output  BitNo  XOR of all words accepted this session
DropCount  output  16  words dropped while not UNLOCKED, saturates at 16'hFFFF

Behaviour:
- Reset (Rst_n=0 at edge) puts state in LOCKED and clears every output and internal register to 0, including key_reg and timer. Reset mid-session or mid-lockout aborts immediately.
- State machine states: LOCKED, CHECK, UNLOCKED, LOCKOUT.
- LOCKED:
  - KeyLoad=1: key_reg<=InputKey, go to CHECK.
  - DataInValid=1: DropCount++ (saturating).
- CHECK (exactly 1 cycle): compares key_reg against the GKey value present in this cycle.
  - Match: go to UNLOCKED; FailCount<=0, WordCount<=0, Checksum<=0.
  - Mismatch with FailCount+1==MaxFail: FailCount<=MaxFail, timer<=LockoutCycles-1, go to LOCKOUT.
  - Other mismatch: FailCount++, go to LOCKED.
  - KeyLoad is ignored in CHECK. DataInValid drops the word (DropCount++).
- UNLOCKED, priority highest first:
  1. GKey!=key_reg: go to LOCKED this edge, and the word in this cycle is dropped (DropCount++).
  2. Accept: if DataInValid=1, DataOut<=DataIn, Data_valid<=1 on the next edge (latency 1), Checksum<=Checksum^DataIn, WordCount++.
  3. KeyLoad=1: after any accept in the same cycle, key_reg<=InputKey and go to CHECK.
  4. Expiry: if the accepted word makes WordCount==SessionWords, go to LOCKED; that word is still delivered. Expiry has priority over KeyLoad.
- LOCKOUT:
  - timer decrements each cycle. When timer==0, FailCount<=0 and go to LOCKED.
  - KeyLoad is ignored (key_reg unchanged). DataInValid drops words (DropCount++).
  - Total LOCKOUT residency is exactly LockoutCycles cycles.
- Outputs:
  - Data_valid is high for exactly one cycle per accepted word.
  - DataOut holds its last accepted value otherwise; it is never driven with unauthenticated data.
  - WordCount and Checksum hold their values after leaving UNLOCKED until the next successful CHECK.
- Unlocked and LockedOut are registered state decodes, asserted in the same cycle the state is entered.
- Back-to-back DataInValid in UNLOCKED yields back-to-back Data_valid with no bubbles.

Test Plan:
- Reset, GKey=64'hA5A5_0000_FFFF_1234, KeyLoad with InputKey equal to GKey -> Unlocked=1 two edges after KeyLoad; FailCount=0.
- Unlocked, send 3 words 64'h1, 64'h2, 64'h4 back-to-back -> three consecutive Data_valid pulses each 1 cycle after input; DataOut matches each word; WordCount=3, Checksum=64'h7.
- Three KeyLoads with InputKey=64'h0, GKey nonzero -> FailCount 1, 2, then LockedOut=1. LockedOut stays high exactly 16 cycles; a correct KeyLoad during lockout is ignored. After lockout, FailCount=0 and state is LOCKED.
- SessionWords=4, stream 5 words while unlocked -> 4 Data_valid pulses, Unlocked drops after the 4th, 5th word dropped, DropCount=1.
- While unlocked, change GKey in the same cycle as DataInValid -> no Data_valid, Unlocked=0 next edge, DropCount increments.
- Assert Rst_n=0 mid-lockout with FailCount=3 -> next edge all outputs 0, state LOCKED; a correct KeyLoad then unlocks normally.
